// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and the stored command word.
package alu_seq_pkg;

    localparam int unsigned ALU_DATA_W = 4;
    localparam int unsigned ALU_OP_W   = 2;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_DATA_W-1:0] a;
    } cmd_t;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store: DEPTH command registers, one synchronous write port, one asynchronous read port.
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  cmd_t             wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output cmd_t             rd_data
);

    cmd_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/alu_op_sequencer.sv
// Stores a short (a, b, op) program and replays it to the ALU over a registered valid/ready port.
// Optional issued-command counter output enabled by ALU_SEQ_ISSUE_COUNT_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned  DEPTH  = 8,
    parameter int unsigned  DATA_W = ALU_DATA_W,
    parameter int unsigned  OP_W   = ALU_OP_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_op,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done
`ifdef ALU_SEQ_ISSUE_COUNT_EN
    ,
    output logic [7:0]        issued_cnt
`endif
);

    state_t           state;
    logic [CNT_W-1:0] rd;
    logic [IDX_W-1:0] rd_idx;
    logic             push;
    logic             start_acc;
    logic             hs;
    logic             last;
    logic             not_full;
    cmd_t             wr_cmd;
    cmd_t             rd_cmd;

    assign push      = (state == ST_IDLE) && in_valid && in_ready && !clear;
    assign start_acc = (state == ST_IDLE) && start && !clear && !push && (count != '0);
    assign hs        = out_valid && out_ready;
    assign last      = (rd == count);
    assign not_full  = (count != CNT_W'(DEPTH));
    // A wrap reads entry 0, which also keeps the read index inside the array when count == DEPTH.
    assign rd_idx    = last ? '0 : rd[IDX_W-1:0];
    assign wr_cmd    = '{op: in_op, b: in_b, a: in_a};

    alu_seq_prog_mem #(
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clk     (clk),
        .we      (push),
        .wr_idx  (count[IDX_W-1:0]),
        .wr_data (wr_cmd),
        .rd_idx  (rd_idx),
        .rd_data (rd_cmd)
    );

    // Sequencer FSM with registered handshake, status and command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            rd        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clear) begin
                        count    <= '0;
                        in_ready <= 1'b1;
                    end else if (push) begin
                        count    <= count + CNT_W'(1);
                        in_ready <= (count + CNT_W'(1)) != CNT_W'(DEPTH);
                    end else if (start_acc) begin
                        out_a     <= rd_cmd.a;
                        out_b     <= rd_cmd.b;
                        out_op    <= rd_cmd.op;
                        out_valid <= 1'b1;
                        rd        <= CNT_W'(1);
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        rd        <= '0;
                        busy      <= 1'b0;
                        in_ready  <= not_full;
                        state     <= ST_IDLE;
                    end else if (hs) begin
                        if (!last || loop_en) begin
                            out_a  <= rd_cmd.a;
                            out_b  <= rd_cmd.b;
                            out_op <= rd_cmd.op;
                            rd     <= last ? CNT_W'(1) : rd + CNT_W'(1);
                        end else begin
                            out_valid <= 1'b0;
                            rd        <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done     <= 1'b0;
                    in_ready <= not_full;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ISSUE_COUNT_EN
    // Counts consumer handshakes, including one coinciding with abort; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            issued_cnt <= '0;
        end else if (hs) begin
            issued_cnt <= issued_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: program/issue model in queues, monitor checks every handshake.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } cmd_s;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic       clear;
    logic       start;
    logic       abort;
    logic       loop_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [1:0] out_op;
    logic [3:0] count;
    logic       busy;
    logic       done;
`ifdef ALU_SEQ_ISSUE_COUNT_EN
    logic [7:0] issued_cnt;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .clear     (clear),
        .start     (start),
        .abort     (abort),
        .loop_en   (loop_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .count     (count),
        .busy      (busy),
        .done      (done)
`ifdef ALU_SEQ_ISSUE_COUNT_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    cmd_s prog[$];
    cmd_s exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   hs_total = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    logic stalled = 1'b0;
    cmd_s held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_s rand_cmd();
        cmd_s c;
        c.a  = 4'($urandom_range(0, 15));
        c.b  = 4'($urandom_range(0, 15));
        c.op = 2'($urandom_range(0, 3));
        return c;
    endfunction

    function automatic cmd_s mk(input int a, input int b, input logic [1:0] op);
        cmd_s c;
        c.a  = 4'(a);
        c.b  = 4'(b);
        c.op = op;
        return c;
    endfunction

    // Consumer ready pattern: 0 always, 1 toggling, 2 random, other never.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every handshake pops the scoreboard; stalled commands must hold.
    initial begin
        cmd_s e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && out_valid)
                    check("hold", {out_op, out_b, out_a}, {held.op, held.b, held.a});
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    hs_total++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_issue: got op=%0d b=%0d a=%0d, none expected", out_op, out_b, out_a);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue", {out_op, out_b, out_a}, {e.op, e.b, e.a});
                    end
                end
                stalled = out_valid && !out_ready;
                held.a  = out_a;
                held.b  = out_b;
                held.op = out_op;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_cmd"}, {out_op, out_b, out_a}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // One-cycle push attempt; the model decides whether it is accepted.
    task automatic push_cmd(input cmd_s c);
        logic exp_rdy;
        exp_rdy  = (prog.size() < DEPTH);
        in_valid = 1'b1;
        in_a     = c.a;
        in_b     = c.b;
        in_op    = c.op;
        @(negedge clk);
        check("in_ready", in_ready, exp_rdy);
        tick();
        in_valid = 1'b0;
        if (exp_rdy) prog.push_back(c);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prog.delete();
        check("clear_count", count, 0);
        check("clear_in_ready", in_ready, 1);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (prog.size() > 0) begin
            foreach (prog[i]) exp_q.push_back(prog[i]);
            check("start_latency", out_valid, 1);
            check("start_busy", busy, 1);
        end else begin
            check("empty_start_valid", out_valid, 0);
            check("empty_start_busy", busy, 0);
        end
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 400 && done_cnt == d0; k++) tick();
        if (done_cnt == d0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done pulse, required one within 400 cycles");
        end
        tick();
        tick();
        check("done_once", done_cnt - d0, 1);
        check("drained", exp_q.size(), 0);
        check("count_kept", count, prog.size());
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        int h0;
        int d0;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        clear = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // Directed three-command program, full throughput.
        push_cmd(mk(3, 5, ALU_ADD));
        push_cmd(mk(9, 4, ALU_SUB));
        push_cmd(mk(6, 3, ALU_AND));
        check("count3", count, 3);
        start_run();
        wait_done();
`ifdef ALU_SEQ_ISSUE_COUNT_EN
        check("issued_cnt", issued_cnt, 3);
`endif

        // Same program replayed with a toggling consumer.
        ready_mode = 1;
        h0 = hs_total;
        start_run();
        wait_done();
        check("toggle_handshakes", hs_total - h0, 3);

        // Fill to capacity, then attempt overflow pushes.
        ready_mode = 0;
        do_clear();
        for (int i = 0; i < DEPTH; i++) push_cmd(rand_cmd());
        check("count_full", count, DEPTH);
        for (int i = 0; i < 2; i++) push_cmd(rand_cmd());
        check("count_no_overflow", count, DEPTH);
        do_clear();

        // Looping two-command program, loop_en dropped after five handshakes.
        push_cmd(rand_cmd());
        push_cmd(rand_cmd());
        loop_en = 1'b1;
        h0 = hs_total;
        start_run();
        foreach (prog[i]) exp_q.push_back(prog[i]);
        foreach (prog[i]) exp_q.push_back(prog[i]);
        for (int k = 0; k < 100 && (hs_total - h0) < 5; k++) tick();
        loop_en = 1'b0;
        wait_done();
        check("loop_handshakes", hs_total - h0, 6);

        // Abort after the first handshake; the same-cycle handshake still consumes entry 1.
        do_clear();
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
        d0 = done_cnt;
        h0 = hs_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(prog[0]);
        exp_q.push_back(prog[1]);
        for (int k = 0; k < 50 && (hs_total - h0) < 1; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        tick();
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_drained", exp_q.size(), 0);
        check("abort_count", count, 3);
        start_run();
        wait_done();

        // Start on an empty program is ignored.
        do_clear();
        start_run();
        tick();
        check("empty_idle_valid", out_valid, 0);
        check("empty_idle_busy", busy, 0);

        // Reset while issuing against a stalled consumer.
        ready_mode = 3;
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
        tick();
        start_run();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prog.delete();
        exp_q.delete();
        check_reset_state("midrst");

        // Randomized programs, lengths and consumer patterns.
        for (int r = 0; r < 14; r++) begin
            ready_mode = 0;
            do_clear();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                push_cmd(rand_cmd());
            end
            check("rand_count", count, n);
            ready_mode = $urandom_range(0, 2);
            tick();
            start_run();
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
